ras_ckpt: RTL

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_pkg.sv | 29 ++
 rtl/ras_ckpt_table.sv | 100 ++++++++++
 rtl/ras_ckpt.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ras_pkg.sv
// ras_pkg -- shared types and sizing for the checkpointed return-address stack.
//
// Holds the default configuration of the stack, the pointer widths derived from
// it, and ckpt_t, the snapshot a branch takes of the stack:
//   tosp  : top-of-stack pointer at the time of the branch
//   count : number of valid entries at the time of the branch
//   top   : the value sitting at mem[tosp] at the time of the branch
// ckpt_t is sized from the localparams here. An instance of ras_ckpt whose
// WIDTH/DEPTH differ from RAS_WIDTH/RAS_DEPTH therefore needs these edited to
// match.
package ras_pkg;

  localparam int RAS_WIDTH = 32;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_NCKPT = 4;

  // tosp indexes DEPTH slots; count runs 0..DEPTH inclusive, so it needs one more bit.
  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
  localparam int ID_W   = $clog2(RAS_NCKPT);
  localparam int NCNT_W = $clog2(RAS_NCKPT + 1);

  typedef struct packed {
    logic [PTR_W-1:0]     tosp;
    logic [CNT_W-1:0]     count;
    logic [RAS_WIDTH-1:0] top;
  } ckpt_t;

endpackage

// File: rtl/ras_ckpt_table.sv
// ras_ckpt_table -- in-order FIFO of stack checkpoints.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   alloc           request a new checkpoint (granted when not busy and no restore)
//   alloc_entry     snapshot stored into the tail slot on a granted alloc
//   retire          free the oldest checkpoint (ignored when empty or on rollback)
//   rollback        roll back to rollback_id
//   rollback_id     checkpoint to restore
//   rollback_hit    rollback is asserted and rollback_id is outstanding
//   rollback_entry  snapshot stored at rollback_id (combinational)
//   tail            id that a branch in this cycle receives
//   busy            every checkpoint slot is in use
module ras_ckpt_table
  import ras_pkg::*;
#(
  parameter int NCKPT = RAS_NCKPT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc,
  input  ckpt_t                    alloc_entry,
  input  logic                     retire,
  input  logic                     rollback,
  input  logic [$clog2(NCKPT)-1:0] rollback_id,
  output logic                     rollback_hit,
  output ckpt_t                    rollback_entry,
  output logic [$clog2(NCKPT)-1:0] tail,
  output logic                     busy
);
  localparam int IW = $clog2(NCKPT);
  localparam int NW = $clog2(NCKPT + 1);

  logic [IW-1:0] head_reg, head_next;
  logic [IW-1:0] tail_reg, tail_next;
  logic [NW-1:0] ncount_reg, ncount_next;
  logic [IW-1:0] age;
  logic          do_alloc;
  logic          do_retire;
  ckpt_t         entry_q [NCKPT];

  // Distance of rollback_id from the oldest entry; NCKPT is a power of two so
  // the subtraction wraps naturally. The id is live when that distance is
  // below the number of outstanding checkpoints, and the same distance is the
  // number of entries that survive the rollback.
  assign age          = rollback_id - head_reg;
  assign rollback_hit = rollback && (NW'(age) < ncount_reg);
  assign busy         = (ncount_reg == NW'(NCKPT));
  assign tail         = tail_reg;

  // A restore frees the target and everything younger, so a same-cycle
  // allocation would be lost; a close_valid alongside close_invalid is dropped.
  assign do_alloc  = alloc && !busy && !rollback_hit;
  assign do_retire = retire && !rollback && (ncount_reg != '0);

  assign rollback_entry = entry_q[rollback_id];

  always_comb begin
    head_next   = head_reg;
    tail_next   = tail_reg;
    ncount_next = ncount_reg;
    if (rollback_hit) begin
      tail_next   = rollback_id;
      ncount_next = NW'(age);
    end else begin
      if (do_alloc)  tail_next = tail_reg + IW'(1);
      if (do_retire) head_next = head_reg + IW'(1);
      case ({do_alloc, do_retire})
        2'b10:   ncount_next = ncount_reg + NW'(1);
        2'b01:   ncount_next = ncount_reg - NW'(1);
        default: ncount_next = ncount_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      ncount_reg <= '0;
    end else begin
      head_reg   <= head_next;
      tail_reg   <= tail_next;
      ncount_reg <= ncount_next;
    end
  end

  // Snapshot storage needs no reset: a slot is only read while outstanding.
  genvar gi;
  generate
    for (gi = 0; gi < NCKPT; gi++) begin : g_entry
      ckpt_t entry_reg;
      always_ff @(posedge clk) begin
        if (do_alloc && (tail_reg == IW'(gi))) entry_reg <= alloc_entry;
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/ras_ckpt.sv
// ras_ckpt -- circular return-address stack with branch checkpoints.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   push, din      push din (overwrites the oldest entry when full)
//   pop            pop the top of stack
//   dout           top of stack, 0 when empty (combinational)
//   empty, full    count == 0 / count == DEPTH
//   branch         take a checkpoint of {tosp, count, top}; ckpt_id is its id
//   busy           all NCKPT checkpoints are outstanding
//   close_valid    retire the oldest checkpoint
//   close_invalid  restore the stack from checkpoint close_id and free it and
//                  all younger checkpoints
//   close_id       checkpoint to restore
// Optional (macro RAS_CKPT_STATS_EN):
//   ovf_cnt        saturating count of pushes made while full
//   udf_cnt        saturating count of pops made while empty
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int WIDTH = RAS_WIDTH,
  parameter int DEPTH = RAS_DEPTH,
  parameter int NCKPT = RAS_NCKPT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  input  logic                     branch,
  output logic [$clog2(NCKPT)-1:0] ckpt_id,
  output logic                     busy,
  input  logic                     close_valid,
  input  logic                     close_invalid,
  input  logic [$clog2(NCKPT)-1:0] close_id
`ifdef RAS_CKPT_STATS_EN
  ,
  output logic [15:0]              ovf_cnt,
  output logic [15:0]              udf_cnt
`endif
);
  localparam int SPW = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0]   tosp_reg, tosp_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             wr_en;
  logic [SPW-1:0]   wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] top_val;
  logic             restore;
  ckpt_t            snap;
  ckpt_t            saved;

  assign top_val = mem[tosp_reg];
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign dout    = empty ? '0 : top_val;

  // Snapshot reflects the state before this cycle's push/pop.
  assign snap = '{tosp: tosp_reg, count: count_reg, top: top_val};

  ras_ckpt_table #(
    .NCKPT(NCKPT)
  ) u_table (
    .clk           (clk),
    .reset         (reset),
    .alloc         (branch),
    .alloc_entry   (snap),
    .retire        (close_valid),
    .rollback      (close_invalid),
    .rollback_id   (close_id),
    .rollback_hit  (restore),
    .rollback_entry(saved),
    .tail          (ckpt_id),
    .busy          (busy)
  );

  always_comb begin
    tosp_next  = tosp_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_addr    = tosp_reg;
    wr_data    = din;
    if (restore) begin
      // Pushes after the branch may have overwritten the saved top slot.
      tosp_next  = saved.tosp;
      count_next = saved.count;
      wr_en      = 1'b1;
      wr_addr    = saved.tosp;
      wr_data    = saved.top;
    end else if (push && pop) begin
      wr_en = 1'b1;
    end else if (push) begin
      tosp_next = tosp_reg + SPW'(1);
      wr_en     = 1'b1;
      wr_addr   = tosp_reg + SPW'(1);
      if (!full) count_next = count_reg + CW'(1);
    end else if (pop && !empty) begin
      tosp_next  = tosp_reg - SPW'(1);
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tosp_reg  <= '0;
      count_reg <= '0;
    end else begin
      tosp_reg  <= tosp_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef RAS_CKPT_STATS_EN
  logic [15:0] ovf_reg, udf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_reg <= '0;
      udf_reg <= '0;
    end else begin
      if (!restore && push && full && (ovf_reg != 16'hFFFF)) ovf_reg <= ovf_reg + 16'd1;
      if (!restore && pop && empty && (udf_reg != 16'hFFFF)) udf_reg <= udf_reg + 16'd1;
    end
  end

  assign ovf_cnt = ovf_reg;
  assign udf_cnt = udf_reg;
`endif

endmodule
